// File: rtl/axis_output_pipe_pkg.sv
// Shared widths for the conv-engine stream pipes and the output pipe.
// Defaults here match the production engine build.
package axis_output_pipe_pkg;

    localparam int PIPE_UNITS            = 8;
    localparam int PIPE_CORES            = 4;
    localparam int PIPE_WORD_WIDTH       = 8;
    localparam int OUT_PIPE_M_DATA_WIDTH = 64;
    localparam int OUT_PIPE_DEBUG_WIDTH  = 32;

    // Counter width for a beat index that must hold at least one bit.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/axis_output_pipe_transpose.sv
// Combinational core-major -> pixel-major word permutation.
// Output word u*CORES+c is input word c*UNITS+u; also used by the max-pool path.
module axis_out_transpose
    import axis_output_pipe_pkg::*;
#(
    parameter int UNITS      = PIPE_UNITS,
    parameter int CORES      = PIPE_CORES,
    parameter int WORD_WIDTH = PIPE_WORD_WIDTH
) (
    input  logic [CORES*UNITS*WORD_WIDTH-1:0] core_major,
    output logic [CORES*UNITS*WORD_WIDTH-1:0] pixel_major
);

    localparam int WORDS = CORES * UNITS;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign pixel_major[gi*WORD_WIDTH +: WORD_WIDTH] =
            core_major[((gi % CORES) * UNITS + gi / CORES) * WORD_WIDTH +: WORD_WIDTH];
    end

endmodule

// File: rtl/axis_output_pipe.sv
// Engine result beat -> transposed, serialized AXI-Stream for the S2MM DMA.
// Define OUTPUT_PIPE_DEBUG_EN to add the debug_config beat/packet counters.
module axis_output_pipe
    import axis_output_pipe_pkg::*;
#(
    parameter int UNITS                       = PIPE_UNITS,
    parameter int CORES                       = PIPE_CORES,
    parameter int WORD_WIDTH                  = PIPE_WORD_WIDTH,
    parameter int M_DATA_WIDTH                = OUT_PIPE_M_DATA_WIDTH,
    parameter int DEBUG_CONFIG_WIDTH_OUT_PIPE = OUT_PIPE_DEBUG_WIDTH
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    input  logic [CORES*UNITS*WORD_WIDTH-1:0]      s_axis_tdata,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    output logic [M_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0]              m_axis_tkeep
`ifdef OUTPUT_PIPE_DEBUG_EN
    ,
    output logic [DEBUG_CONFIG_WIDTH_OUT_PIPE-1:0] debug_config
`endif
);

    localparam int WORDS  = CORES * UNITS;
    localparam int WPB    = M_DATA_WIDTH / WORD_WIDTH;
    localparam int BEATS  = WORDS / WPB;
    localparam int CNT_W  = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((WORDS * WORD_WIDTH) % M_DATA_WIDTH != 0 || M_DATA_WIDTH % WORD_WIDTH != 0
        || DEBUG_CONFIG_WIDTH_OUT_PIPE < 32) begin : g_bad_cfg
        $error("axis_output_pipe: engine beat must split into whole DMA beats of whole words");
    end

    typedef enum logic {ST_EMPTY, ST_SEND} state_t;

    state_t                          state_reg, state_next;
    logic [CNT_W-1:0]                count_reg, count_next;
    logic                            last_reg;
    logic [WORDS*WORD_WIDTH-1:0]     buffer_reg;
    logic [WORDS*WORD_WIDTH-1:0]     transposed;
    logic                            at_last;
    logic                            s_hs;

    axis_out_transpose #(
        .UNITS      (UNITS),
        .CORES      (CORES),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_transpose (
        .core_major  (s_axis_tdata),
        .pixel_major (transposed)
    );

    assign at_last       = (count_reg == LAST_CNT);
    // Accepting while the final beat drains lets the next engine beat follow with no bubble.
    assign s_axis_tready = (state_reg == ST_EMPTY) || (m_axis_tready && at_last);
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = (state_reg == ST_SEND);
    assign m_axis_tlast  = last_reg && at_last && (state_reg == ST_SEND);
    assign m_axis_tdata  = buffer_reg[M_DATA_WIDTH * 32'(count_reg) +: M_DATA_WIDTH];
    assign m_axis_tkeep  = '1;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (s_axis_tvalid) begin
                    state_next = ST_SEND;
                    count_next = '0;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    if (!at_last) begin
                        count_next = count_reg + CNT_W'(1);
                    end else begin
                        count_next = '0;
                        state_next = s_axis_tvalid ? ST_SEND : ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= ST_EMPTY;
            count_reg <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (s_hs) begin
                last_reg <= s_axis_tlast;
            end
        end
    end

    // Data path carries no reset; its contents are only observed while in ST_SEND.
    always_ff @(posedge aclk) begin
        if (s_hs) begin
            buffer_reg <= transposed;
        end
    end

`ifdef OUTPUT_PIPE_DEBUG_EN
    logic [15:0] beat_cnt_reg;
    logic [15:0] tlast_cnt_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt_reg  <= '0;
            tlast_cnt_reg <= '0;
        end else begin
            if (s_hs && beat_cnt_reg != 16'hFFFF) begin
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && tlast_cnt_reg != 16'hFFFF) begin
                tlast_cnt_reg <= tlast_cnt_reg + 16'd1;
            end
        end
    end

    assign debug_config = DEBUG_CONFIG_WIDTH_OUT_PIPE'({tlast_cnt_reg, beat_cnt_reg});
`endif

endmodule

// File: doc/axis_output_pipe.md
Name: axis_output_pipe

Overview:
Return-path counterpart of the conv-engine input pipe. It accepts one wide result beat per handshake from the conv engine (CORES×UNITS words, core-major). It transposes the beat to pixel-major order (core index fastest) and serializes it into narrow AXI-Stream beats for the output DMA, carrying packet tlast through. It sits between the conv engine's output stage and the S2MM DMA.

Parameters:
UNITS, 8, pixel rows per core beat
CORES, 4, parallel cores per beat
WORD_WIDTH, 8, bits per output word
M_DATA_WIDTH, 64, DMA stream width; (CORES*UNITS*WORD_WIDTH) % M_DATA_WIDTH == 0 and M_DATA_WIDTH % WORD_WIDTH == 0 (elaboration error otherwise)
DEBUG_CONFIG_WIDTH_OUT_PIPE, 32, width of debug_config output (used only with feature)

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_axis_tready  out  1  engine-side ready
s_axis_tvalid  in  1  engine-side valid
s_axis_tlast  in  1  last engine beat of output packet
s_axis_tdata  in  CORES*UNITS*WORD_WIDTH  word index c*UNITS+u, word 0 at LSB
m_axis_tready  in  1  DMA ready
m_axis_tvalid  out  1  DMA valid
m_axis_tlast  out  1  last DMA beat of packet
m_axis_tdata  out  M_DATA_WIDTH  serialized words, lowest word at LSB
m_axis_tkeep  out  M_DATA_WIDTH/8  always all ones
debug_config  out  DEBUG_CONFIG_WIDTH_OUT_PIPE  present only with OUTPUT_PIPE_DEBUG_EN

Behaviour:
- Derived constants: WORDS = CORES*UNITS; WPB = M_DATA_WIDTH/WORD_WIDTH; BEATS = WORDS/WPB; count width = max(1, clog2(BEATS)).
- Transpose on load: buffer word j = u*CORES + c takes input word c*UNITS + u. The load is a pure wiring permutation into the register.
- State machine:
  - EMPTY: m_axis_tvalid=0, s_axis_tready=1. On s_valid: load buffer, latch tlast into last_r, count←0, go to SEND.
  - SEND: m_axis_tvalid=1, m_axis_tdata = buffer words [count*WPB +: WPB].
    - On m handshake with count<BEATS-1: count++.
    - On m handshake with count==BEATS-1: if s_valid, reload buffer and last_r, count←0, stay in SEND; otherwise go to EMPTY.
- s_axis_tready = (state==EMPTY) || (m_axis_tready && count==BEATS-1). This gives gapless streaming: 1 engine beat per BEATS cycles when the DMA never stalls.
- m_axis_tlast = last_r && count==BEATS-1 && state==SEND.
- Latency: an engine beat accepted at cycle t yields its first DMA beat valid at t+1.
- m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready (AXIS rule).
- BEATS==1: every handshake reloads; acts as a registered pass-through with transpose.
- Reset (any cycle, including mid-packet): state→EMPTY, count→0, last_r→0, m_axis_tvalid=0 and m_axis_tlast=0 from the next cycle. The partially sent beat is discarded. The buffer need not be reset.
- s_axis_tvalid deasserting mid-packet is legal; the block idles in EMPTY.

Optional Feature:
- Macro OUTPUT_PIPE_DEBUG_EN.
- Defined: debug_config port exists and is registered. Bits [15:0] hold a saturating count of engine beats accepted. Bits [31:16] hold a saturating count of m_axis_tlast handshakes. Both counts clear on areset.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared params include: DMA width default and the debug width constant, next to existing pipe widths.
- State encoding is a local two-state localparam, not shared.
- One natural sub-module: axis_out_transpose, a combinational CORES×UNITS→UNITS×CORES word permutation. It is reusable by the max-pool path.
- The FSM and serializer stay in the top.

Test Plan:
- UNITS=4, CORES=2, WORD_WIDTH=8, M_DATA_WIDTH=32 (BEATS=2). Input word c*4+u = 0x10*c+u, tlast=1, m_ready=1 → beat0 0x11011000 tlast=0, beat1 0x13031202 tlast=1, first valid one cycle after input handshake.
- Back-to-back 4 engine beats, tvalid and m_ready held high → 8 DMA beats in 8 consecutive cycles, s_tready high exactly on the cycles where count==1; only the final beat of a tlast input carries tlast.
- m_ready random 50% → tdata/tlast stable under stall, no word lost/duplicated; compare against a scoreboard.
- areset pulsed after beat0 of a packet → m_valid low next cycle; the new input then streams from its beat0.
- BEATS=1 config (M_DATA_WIDTH=64) → one output per input, data equals the transposed input.
- With OUTPUT_PIPE_DEBUG_EN: 5 inputs, 2 with tlast → debug_config = 0x00020005.
